score_event_gen: RTL

Front-end scoring judge for the LED score-counter chain. It detects a player key press and grades it against the target LED window. It then emits exactly one single-cycle `plus2`, `plus1` or `minus2` pulse per graded press, and these pulses drive the lowest `scoreCounterForOne` digit. Graded events are buffered, and pulses are spaced so that carry/borrow ripple (`incrementOutPos`/`incrementOutNeg`) settles between events.

---
 rtl/score_pkg.sv | 33 +++
 rtl/key_edge.sv | 33 +++
 rtl/score_event_gen.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// Shared types and defaults for the score-event chain.
// The event enum is common to the judge and to the score-counter digits.
package score_pkg;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_PLUS2,
        EV_PLUS1,
        EV_MINUS2
    } score_ev_t;

    localparam int DEFAULT_WINDOW = 8;
    localparam int DEFAULT_GAP    = 2;
    localparam int DEFAULT_DEPTH  = 4;

    // Grade one press from the lit state, the hit flag and the age comparisons.
    function automatic score_ev_t grade_press(
        input logic lit,
        input logic hit_taken,
        input logic early,
        input logic in_window
    );
        score_ev_t ev;
        ev = EV_MINUS2;
        if (lit && !hit_taken && early) begin
            ev = EV_PLUS2;
        end else if (lit && !hit_taken && in_window) begin
            ev = EV_PLUS1;
        end
        return ev;
    endfunction

endpackage

// File: rtl/key_edge.sv
// Two-flop synchronizer plus rising-edge detector for one asynchronous key.
// A press is reported only against a low level that was actually sampled,
// so a key held through reset does not produce a press on release.
module key_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    output logic press_o
);

    logic       s1_q;
    logic       s2_q;
    logic       s3_q;
    logic [2:0] smp_vld_q;

    // Synchronizer chain, edge-detect flop and sample-valid shift register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            smp_vld_q <= 3'b000;
        end else begin
            s1_q      <= key_i;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            smp_vld_q <= {smp_vld_q[1:0], 1'b1};
        end
    end

    assign press_o = s2_q & ~s3_q & smp_vld_q[2];

endmodule

// File: rtl/score_event_gen.sv
// Front-end scoring judge: grades key presses against the target LED window
// and issues spaced one-cycle plus2/plus1/minus2 pulses from an event FIFO.
module score_event_gen
    import score_pkg::*;
#(
    parameter int WINDOW = DEFAULT_WINDOW,
    parameter int GAP    = DEFAULT_GAP,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     Reset,
    input  logic                     key_raw,
    input  logic                     target_lit,
    output logic                     plus2,
    output logic                     plus1,
    output logic                     minus2,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   pending
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int AGE_W = $clog2(WINDOW + 1);
    localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(WINDOW);
    localparam logic [AGE_W-1:0] AGE_HALF = AGE_W'(WINDOW / 2);
    localparam logic [GAP_W-1:0] GAP_LD   = GAP_W'(GAP);
    localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);

    // Key path
    logic             press;

    // Target window tracking
    logic             lit_q;
    logic             rise;
    logic [AGE_W-1:0] age_q, age_d;
    logic             hit_q, hit_d;
    logic [AGE_W-1:0] eff_age;
    logic             eff_hit;
    score_ev_t        grade_ev;
    logic             grade_pos;

    // Event FIFO
    score_ev_t        mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full;
    logic             empty;
    logic             push_ok;
    logic             drop;
    score_ev_t        head;

    // Issue stage
    logic             pop;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             ovf_q, ovf_d;
    logic             plus2_q, plus2_d;
    logic             plus1_q, plus1_d;
    logic             minus2_q, minus2_d;

    key_edge u_key (
        .clk_i   (clk),
        .rst_i   (Reset),
        .key_i   (key_raw),
        .press_o (press)
    );

    // Grade the press of this cycle; a press on the rise cycle sees a fresh window.
    always_comb begin
        rise      = target_lit & ~lit_q;
        eff_age   = rise ? '0 : age_q;
        eff_hit   = rise ? 1'b0 : hit_q;
        grade_ev  = grade_press(target_lit, eff_hit,
                                eff_age < AGE_HALF, eff_age < AGE_MAX);
        grade_pos = (grade_ev == EV_PLUS2) || (grade_ev == EV_PLUS1);

        age_d = age_q;
        if (rise) begin
            age_d = '0;
        end else if (target_lit && (age_q < AGE_MAX)) begin
            age_d = age_q + AGE_W'(1);
        end

        // A positive hit on the rise cycle must survive the rise clear.
        hit_d = hit_q;
        if (rise) begin
            hit_d = 1'b0;
        end
        if (press && grade_pos) begin
            hit_d = 1'b1;
        end
    end

    // Window state: previous lit level, saturating age and one-hit-per-interval flag.
    always_ff @(posedge clk) begin
        if (Reset) begin
            lit_q <= 1'b0;
            age_q <= '0;
            hit_q <= 1'b0;
        end else begin
            lit_q <= target_lit;
            age_q <= age_d;
            hit_q <= hit_d;
        end
    end

    // FIFO bookkeeping, pacing counter and next pulse values.
    always_comb begin
        full    = (cnt_q == FULL_CNT);
        empty   = (cnt_q == '0);
        pop     = !empty && (gap_q == '0);
        push_ok = press && (!full || pop);
        drop    = press && full && !pop;
        head    = mem_q[rd_q];

        wr_d = push_ok ? wr_q + AW'(1) : wr_q;
        rd_d = pop     ? rd_q + AW'(1) : rd_q;

        cnt_d = cnt_q;
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        gap_d = gap_q;
        if (pop) begin
            gap_d = GAP_LD;
        end else if (gap_q != '0) begin
            gap_d = gap_q - GAP_W'(1);
        end

        ovf_d    = ovf_q | drop;
        plus2_d  = pop && (head == EV_PLUS2);
        plus1_d  = pop && (head == EV_PLUS1);
        minus2_d = pop && (head == EV_MINUS2);
    end

    // Event storage; contents are only meaningful under the count, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q] <= grade_ev;
        end
    end

    // FIFO pointers, occupancy, pacing, sticky overflow and registered pulses.
    always_ff @(posedge clk) begin
        if (Reset) begin
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            gap_q    <= '0;
            ovf_q    <= 1'b0;
            plus2_q  <= 1'b0;
            plus1_q  <= 1'b0;
            minus2_q <= 1'b0;
        end else begin
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            ovf_q    <= ovf_d;
            plus2_q  <= plus2_d;
            plus1_q  <= plus1_d;
            minus2_q <= minus2_d;
        end
    end

    assign plus2    = plus2_q;
    assign plus1    = plus1_q;
    assign minus2   = minus2_q;
    assign overflow = ovf_q;
    assign pending  = cnt_q;

endmodule
